move_arbiter: RTL and testbench
===============================

Name: move_arbiter

Overview:
- Sequences all piece-motion requests: rotate button, left/right/down buttons and the gravity tick.
- Serializes the requests into one candidate move at a time for the board collision checker, then commits or discards the move based on the checker's verdict.
- Owns the committed orientation. Emits a one-cycle `rot` pulse to rotatefsm for each accepted rotation.
- Sits between the input synchronizers and the board/collision logic.

Parameters:
NUM_ORIENT, 4, number of orientations; rotation wraps modulo this (max 8)
CHK_TIMEOUT, 15, cycles to wait for chk_done before treating the move as rejected
DAS_DELAY, 16, auto-repeat initial delay in cycles (AUTO_REPEAT_EN only)
DAS_RATE, 4, auto-repeat period in cycles (AUTO_REPEAT_EN only)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_rot  in  1  rotate button level, already synchronized
btn_left  in  1  move-left button level
btn_right  in  1  move-right button level
btn_down  in  1  soft-drop button level
grav_tick  in  1  one-cycle gravity pulse
spawn  in  1  new-piece pulse
chk_done  in  1  checker verdict valid, one cycle
chk_ok  in  1  checker verdict: 1 = move legal (qualified by chk_done)
req_valid  out  1  candidate move presented to checker
req_op  out  3  candidate op: 0 NONE, 1 ROT, 2 LEFT, 3 RIGHT, 4 DOWN, 5 GRAV
req_rot  out  3  candidate orientation (next orientation for ROT, current orientation otherwise)
rotation  out  3  committed orientation
rot  out  1  one-cycle pulse to rotatefsm on accepted ROT
move_ok  out  1  one-cycle pulse: move committed
lock_piece  out  1  one-cycle pulse: GRAV rejected, piece must lock
busy  out  1  state != IDLE

Behaviour:
- Reset (async): all outputs are 0, state IDLE, pending bits cleared, edge registers cleared.
- Edge detect: a button's pending bit is set on a registered 0->1 edge. A rising edge in cycle E sets the bit in E+1. grav_tick sets pend_grav directly.
- Held buttons do not repeat (except under AUTO_REPEAT_EN).
- Pending bits are sticky until serviced. A new edge on an already-pending bit is merged, not counted.
- Priority in IDLE: ROT > LEFT > RIGHT > DOWN > GRAV.
- States:
  - IDLE: if any pending bit is set, latch the op, clear its pending bit, and go to WAIT. req_valid rises the next cycle.
  - WAIT: req_valid = 1, req_op/req_rot stable, timeout counter runs.
    - chk_done=1: go to COMMIT.
    - Counter reaches CHK_TIMEOUT: treat as reject and go to COMMIT.
  - COMMIT: lasts one cycle, req_valid = 0.
    - On ok: move_ok = 1. If op is ROT, rotation <= (rotation+1) mod NUM_ORIENT and rot = 1.
    - On reject with op GRAV: lock_piece = 1.
    - Any other reject is silently dropped.
    - Return to IDLE.
- Latency: edge at E -> req_valid at E+2. chk_done at D -> rotation/move_ok/rot at D+1 -> next req_valid at D+3 at the earliest.
- Throughput: one move per 3 cycles minimum.
- chk_done while not in WAIT: ignored.
- spawn has top priority in every state:
  - Next cycle: state IDLE, rotation = 0, all pending bits cleared, req_valid = 0.
  - No move_ok, rot or lock_piece is emitted for an aborted move.
- spawn in the same cycle as chk_done: spawn wins and the verdict is discarded.
- grav_tick arriving while GRAV is in flight: pend_grav is set again and serviced afterwards.
- Rotation wrap: with NUM_ORIENT=4, 3 -> 0. Width is 3 bits; NUM_ORIENT > 8 is illegal (elaboration check).

Optional Feature:
MOVE_ARBITER_AUTO_REPEAT_EN
- Defined: LEFT, RIGHT and DOWN held continuously re-set their pending bit DAS_DELAY cycles after the edge, then every DAS_RATE cycles while still held. Each of the three has its own counter; release clears it. ROT never repeats.
- Undefined: edge-only behaviour, and the counters are not instantiated.

Decomposition:
- Shared package tetris_pkg:
  - op encoding constants (OP_NONE..OP_GRAV)
  - state enum (IDLE, WAIT, COMMIT)
  - default NUM_ORIENT
- One natural sub-module: btn_edge_repeat, one instance per button. It contains the edge register plus the optional DAS counter and outputs a pending-set pulse.

Test Plan:
- Reset mid-WAIT: assert reset with req_valid=1 -> all outputs 0 immediately (async); rotation=0 after release.
- Rotate accepted 5 times, NUM_ORIENT=4: btn_rot edge, chk_done&chk_ok one cycle after req_valid each time -> rotation 1,2,3,0,1; exactly 5 rot pulses; req_rot=1,2,3,0,1.
- Simultaneous btn_rot, btn_left edges and grav_tick in one cycle, checker always ok -> req_op sequence 1,2,5; three move_ok pulses.
- GRAV rejected: grav_tick, chk_done=1 chk_ok=0 -> lock_piece pulse one cycle after chk_done, no move_ok, rotation unchanged.
- Checker silent: btn_left, never assert chk_done -> req_valid high exactly CHK_TIMEOUT cycles, then drops; no move_ok, no lock_piece.
- spawn during WAIT for ROT with rotation=2 -> next cycle req_valid=0, rotation=0, pending cleared; a later chk_done is ignored.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the piece-motion logic.
//   - op encoding carried on req_op
//   - move_arbiter state enum
//   - default orientation count
package tetris_pkg;

  localparam int unsigned NUM_ORIENT_DEFAULT = 4;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ROT   = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_GRAV  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COMMIT
  } state_t;

endpackage

// File: rtl/btn_edge_repeat.sv
// Button edge detector with optional delayed auto-repeat.
// Optional feature macro: MOVE_ARBITER_AUTO_REPEAT_EN (auto-repeat counter).
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   btn          : synchronized button level
//   set          : one-cycle pulse requesting the pending bit be set
module btn_edge_repeat #(
  parameter bit          REPEAT_EN = 1'b0,
  parameter int unsigned DAS_DELAY = 16,
  parameter int unsigned DAS_RATE  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic set
);

  if (REPEAT_EN && (DAS_RATE == 0 || DAS_RATE > DAS_DELAY)) begin : g_bad_das
    $fatal(1, "btn_edge_repeat: need 1 <= DAS_RATE <= DAS_DELAY");
  end

  logic btn_q;
  logic repeat_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

`ifdef MOVE_ARBITER_AUTO_REPEAT_EN
  localparam int unsigned CW = $clog2(DAS_DELAY + 1);

  if (REPEAT_EN) begin : g_das
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep;

    // cnt_q holds cycles since the press; after the first repeat it is
    // rewound so that the next hit lands DAS_RATE cycles later.
    always_comb begin
      cnt_d = '0;
      rep   = 1'b0;
      if (btn && !btn_q) begin
        cnt_d = CW'(1);
      end else if (btn) begin
        if (cnt_q == CW'(DAS_DELAY)) begin
          rep   = 1'b1;
          cnt_d = CW'(DAS_DELAY - DAS_RATE + 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign repeat_set = rep;
  end else begin : g_no_das
    assign repeat_set = 1'b0;
  end
`else
  assign repeat_set = 1'b0;
`endif

  assign set = (btn & ~btn_q) | repeat_set;

endmodule

// File: rtl/move_arbiter.sv
// Serializes rotate/left/right/down/gravity requests into one candidate move
// at a time for the collision checker, then commits or discards it.
// Owns the committed orientation and pulses rot for each accepted rotation.
// Optional feature macro: MOVE_ARBITER_AUTO_REPEAT_EN (held LEFT/RIGHT/DOWN repeat).
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   btn_rot/left/right/down  : synchronized button levels
//   grav_tick, spawn         : one-cycle gravity / new-piece pulses
//   chk_done, chk_ok         : checker verdict strobe and verdict
//   req_valid, req_op, req_rot : candidate move to the checker
//   rotation                 : committed orientation
//   rot, move_ok, lock_piece : one-cycle result pulses
//   busy                     : arbiter not idle
module move_arbiter
  import tetris_pkg::*;
#(
  parameter int unsigned NUM_ORIENT  = NUM_ORIENT_DEFAULT,
  parameter int unsigned CHK_TIMEOUT = 15,
  parameter int unsigned DAS_DELAY   = 16,
  parameter int unsigned DAS_RATE    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_rot,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       grav_tick,
  input  logic       spawn,
  input  logic       chk_done,
  input  logic       chk_ok,
  output logic       req_valid,
  output logic [2:0] req_op,
  output logic [2:0] req_rot,
  output logic [2:0] rotation,
  output logic       rot,
  output logic       move_ok,
  output logic       lock_piece,
  output logic       busy
);

  if (NUM_ORIENT < 1 || NUM_ORIENT > 8) begin : g_bad_orient
    $fatal(1, "move_arbiter: NUM_ORIENT must be 1..8");
  end
  if (CHK_TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "move_arbiter: CHK_TIMEOUT must be >= 1");
  end

  localparam int unsigned CW = $clog2(CHK_TIMEOUT + 1);

  // Pending bit order matches priority: rot, left, right, down, grav.
  logic [4:0] set;

  btn_edge_repeat #(
    .REPEAT_EN (1'b0),
    .DAS_DELAY (DAS_DELAY),
    .DAS_RATE  (DAS_RATE)
  ) u_rot (
    .clock (clock),
    .reset (reset),
    .btn   (btn_rot),
    .set   (set[0])
  );

  btn_edge_repeat #(
    .REPEAT_EN (1'b1),
    .DAS_DELAY (DAS_DELAY),
    .DAS_RATE  (DAS_RATE)
  ) u_left (
    .clock (clock),
    .reset (reset),
    .btn   (btn_left),
    .set   (set[1])
  );

  btn_edge_repeat #(
    .REPEAT_EN (1'b1),
    .DAS_DELAY (DAS_DELAY),
    .DAS_RATE  (DAS_RATE)
  ) u_right (
    .clock (clock),
    .reset (reset),
    .btn   (btn_right),
    .set   (set[2])
  );

  btn_edge_repeat #(
    .REPEAT_EN (1'b1),
    .DAS_DELAY (DAS_DELAY),
    .DAS_RATE  (DAS_RATE)
  ) u_down (
    .clock (clock),
    .reset (reset),
    .btn   (btn_down),
    .set   (set[3])
  );

  assign set[4] = grav_tick;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    rotation_q, rotation_d;
  logic [4:0]    pend_q, pend_d;
  logic [4:0]    clr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          move_ok_q, move_ok_d;
  logic          rot_q, rot_d;
  logic          lock_q, lock_d;
  logic          verdict;
  logic          resolve;
  logic [2:0]    rotation_next;

  assign rotation_next = (rotation_q == 3'(NUM_ORIENT - 1)) ? 3'd0 : rotation_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rotation_d = rotation_q;
    cnt_d      = cnt_q;
    clr        = '0;
    move_ok_d  = 1'b0;
    rot_d      = 1'b0;
    lock_d     = 1'b0;
    verdict    = 1'b0;
    resolve    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q[0]) begin
          op_d = OP_ROT;
          clr  = 5'b00001;
        end else if (pend_q[1]) begin
          op_d = OP_LEFT;
          clr  = 5'b00010;
        end else if (pend_q[2]) begin
          op_d = OP_RIGHT;
          clr  = 5'b00100;
        end else if (pend_q[3]) begin
          op_d = OP_DOWN;
          clr  = 5'b01000;
        end else if (pend_q[4]) begin
          op_d = OP_GRAV;
          clr  = 5'b10000;
        end
        if (clr != '0) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (chk_done) begin
          resolve = 1'b1;
          verdict = chk_ok;
        end else if (cnt_q == CW'(CHK_TIMEOUT - 1)) begin
          resolve = 1'b1;  // timeout counts as a reject
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        // Results are registered on entry to COMMIT so they appear
        // the cycle after the verdict.
        if (resolve) begin
          state_d   = COMMIT;
          move_ok_d = verdict;
          if (verdict && op_q == OP_ROT) begin
            rotation_d = rotation_next;
            rot_d      = 1'b1;
          end
          if (!verdict && op_q == OP_GRAV) begin
            lock_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New edges win over the clear of the bit being serviced.
    pend_d = (pend_q & ~clr) | set;

    // spawn aborts everything, including a verdict arriving this cycle.
    if (spawn) begin
      state_d    = IDLE;
      op_d       = OP_NONE;
      rotation_d = 3'd0;
      cnt_d      = '0;
      pend_d     = '0;
      move_ok_d  = 1'b0;
      rot_d      = 1'b0;
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      rotation_q <= 3'd0;
      pend_q     <= '0;
      cnt_q      <= '0;
      move_ok_q  <= 1'b0;
      rot_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rotation_q <= rotation_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      move_ok_q  <= move_ok_d;
      rot_q      <= rot_d;
      lock_q     <= lock_d;
    end
  end

  assign req_valid  = (state_q == WAIT);
  assign req_op     = req_valid ? op_q : OP_NONE;
  assign req_rot    = !req_valid ? 3'd0 : (op_q == OP_ROT) ? rotation_next : rotation_q;
  assign rotation   = rotation_q;
  assign rot        = rot_q;
  assign move_ok    = move_ok_q;
  assign lock_piece = lock_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_move_arbiter.sv
// Self-checking bench for move_arbiter: cycle-level reference model plus
// directed scenarios with literal expectations, then randomized traffic.
module tb_move_arbiter;

  localparam int NUM_ORIENT  = 4;
  localparam int CHK_TIMEOUT = 15;
  localparam int DAS_DELAY   = 16;
  localparam int DAS_RATE    = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_COMMIT = 2;

  logic       clock;
  logic       reset;
  logic       btn_rot, btn_left, btn_right, btn_down;
  logic       grav_tick, spawn, chk_done, chk_ok;
  logic       req_valid;
  logic [2:0] req_op, req_rot, rotation;
  logic       rot, move_ok, lock_piece, busy;

  move_arbiter #(
    .NUM_ORIENT  (NUM_ORIENT),
    .CHK_TIMEOUT (CHK_TIMEOUT),
    .DAS_DELAY   (DAS_DELAY),
    .DAS_RATE    (DAS_RATE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_rot    (btn_rot),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_down   (btn_down),
    .grav_tick  (grav_tick),
    .spawn      (spawn),
    .chk_done   (chk_done),
    .chk_ok     (chk_ok),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_rot    (req_rot),
    .rotation   (rotation),
    .rot        (rot),
    .move_ok    (move_ok),
    .lock_piece (lock_piece),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;
  int rot_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_phase, m_op, m_age, m_rotation;
  bit [4:0] m_pend, m_new;
  bit [3:0] m_prev, m_btns;
  bit       m_move_ok, m_rot, m_lock, m_ok;
  int       m_held[4];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = PH_IDLE; m_op = 0; m_age = 0; m_rotation = 0;
      m_pend = '0; m_prev = '0;
      m_move_ok = 0; m_rot = 0; m_lock = 0;
      for (int i = 0; i < 4; i++) m_held[i] = 0;
    end else begin
      m_btns = {btn_down, btn_right, btn_left, btn_rot};
      m_new  = {grav_tick, m_btns & ~m_prev};
`ifdef MOVE_ARBITER_AUTO_REPEAT_EN
      for (int i = 1; i < 4; i++) begin
        if (m_btns[i] && m_prev[i]) begin
          m_held[i]++;
          if (m_held[i] >= DAS_DELAY && (m_held[i] - DAS_DELAY) % DAS_RATE == 0) m_new[i] = 1;
        end else begin
          m_held[i] = 0;
        end
      end
`endif
      m_prev = m_btns;
      m_move_ok = 0; m_rot = 0; m_lock = 0;
      if (spawn) begin
        m_phase = PH_IDLE; m_rotation = 0; m_pend = '0;
      end else begin
        case (m_phase)
          PH_IDLE: begin
            for (int i = 0; i < 5; i++) begin
              if (m_pend[i]) begin
                m_op = i + 1; m_pend[i] = 0; m_phase = PH_WAIT; m_age = 0;
                break;
              end
            end
          end
          PH_WAIT: begin
            m_age++;
            if (chk_done || m_age == CHK_TIMEOUT) begin
              m_ok = chk_done && chk_ok;
              if (m_ok) begin
                m_move_ok = 1;
                if (m_op == 1) begin
                  m_rotation = (m_rotation + 1) % NUM_ORIENT;
                  m_rot = 1;
                end
              end else if (m_op == 5) begin
                m_lock = 1;
              end
              m_phase = PH_COMMIT;
            end
          end
          default: m_phase = PH_IDLE;
        endcase
        m_pend = m_pend | m_new;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_valid;
  always @(negedge clock) begin
    e_valid = (m_phase == PH_WAIT);
    check("req_valid", req_valid, e_valid);
    check("req_op", req_op, e_valid ? m_op : 0);
    check("req_rot", req_rot,
          !e_valid ? 0 : (m_op == 1) ? (m_rotation + 1) % NUM_ORIENT : m_rotation);
    check("rotation", rotation, m_rotation);
    check("rot", rot, m_rot);
    check("move_ok", move_ok, m_move_ok);
    check("lock_piece", lock_piece, m_lock);
    check("busy", busy, m_phase != PH_IDLE);
    if (rot) rot_seen++;
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (req_valid) break;
      tick();
    end
    check({name, "_valid_seen"}, req_valid, 1);
  endtask

  task automatic do_rot(input int exp_req_rot, input int exp_rotation);
    btn_rot = 1;
    wait_valid("rot", 10);
    check("rot_req_op", req_op, 1);
    check("rot_req_rot", req_rot, exp_req_rot);
    tick();
    chk_done = 1; chk_ok = 1;
    tick();
    chk_done = 0; chk_ok = 0; btn_rot = 0;
    check("rot_rotation", rotation, exp_rotation);
    check("rot_pulse", rot, 1);
    check("rot_move_ok", move_ok, 1);
    tick();
    check("rot_pulse_end", rot, 0);
    tick();
    tick();
  endtask

  int ops[3];
  int nops, nok, nval, base;
  int exp_rr[5] = '{1, 2, 3, 0, 1};
  int exp_rt[5] = '{1, 2, 3, 0, 1};
  int mode;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; btn_rot = 0; btn_left = 0; btn_right = 0; btn_down = 0;
    grav_tick = 0; spawn = 0; chk_done = 0; chk_ok = 0;
    tick(); tick();
    check("reset_req_valid", req_valid, 0);
    check("reset_rotation", rotation, 0);
    check("reset_busy", busy, 0);
    reset = 0;
    tick(); tick();

    // Five accepted rotations wrap modulo 4.
    base = rot_seen;
    for (int k = 0; k < 5; k++) do_rot(exp_rr[k], exp_rt[k]);
    check("rot_pulse_count", rot_seen - base, 5);

    // Async reset in the middle of WAIT.
    btn_left = 1;
    wait_valid("rst", 10);
    btn_left = 0;
    #2 reset = 1;
    #1;
    check("async_req_valid", req_valid, 0);
    check("async_req_op", req_op, 0);
    check("async_busy", busy, 0);
    check("async_rotation", rotation, 0);
    tick(); tick();
    reset = 0;
    tick();
    check("post_rst_rotation", rotation, 0);
    check("post_rst_req_valid", req_valid, 0);
    tick();

    // Simultaneous rot, left and gravity; checker always accepts.
    btn_rot = 1; btn_left = 1; grav_tick = 1;
    tick();
    grav_tick = 0; btn_rot = 0; btn_left = 0;
    nops = 0; nok = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_valid && !chk_done) begin
        if (nops < 3) ops[nops] = req_op;
        nops++;
        chk_done = 1; chk_ok = 1;
      end else begin
        chk_done = 0; chk_ok = 0;
      end
      if (move_ok) nok++;
      tick();
    end
    chk_done = 0; chk_ok = 0;
    check("multi_count", nops, 3);
    check("multi_op0", ops[0], 1);
    check("multi_op1", ops[1], 2);
    check("multi_op2", ops[2], 5);
    check("multi_move_ok", nok, 3);
    check("multi_rotation", rotation, 1);

    // Gravity rejected -> lock.
    grav_tick = 1;
    tick();
    grav_tick = 0;
    wait_valid("grav", 10);
    check("grav_req_op", req_op, 5);
    chk_done = 1; chk_ok = 0;
    tick();
    chk_done = 0;
    check("grav_lock", lock_piece, 1);
    check("grav_move_ok", move_ok, 0);
    check("grav_rotation", rotation, 1);
    tick();
    check("grav_lock_end", lock_piece, 0);
    tick();

    // Silent checker -> timeout after CHK_TIMEOUT cycles.
    btn_left = 1;
    tick();
    btn_left = 0;
    wait_valid("tmo", 10);
    nval = 0;
    while (req_valid && nval < 40) begin
      nval++;
      tick();
    end
    check("tmo_cycles", nval, CHK_TIMEOUT);
    check("tmo_move_ok", move_ok, 0);
    check("tmo_lock", lock_piece, 0);
    tick(); tick();

    // Spawn during WAIT for ROT at rotation 2.
    do_rot(2, 2);
    btn_rot = 1;
    wait_valid("spawn", 10);
    check("spawn_req_rot", req_rot, 3);
    btn_rot = 0;
    grav_tick = 1;
    tick();
    grav_tick = 0; spawn = 1;
    tick();
    spawn = 0;
    check("spawn_req_valid", req_valid, 0);
    check("spawn_rotation", rotation, 0);
    check("spawn_busy", busy, 0);
    chk_done = 1; chk_ok = 1;
    tick();
    chk_done = 0; chk_ok = 0;
    check("spawn_late_move_ok", move_ok, 0);
    check("spawn_late_rot", rot, 0);
    check("spawn_late_rotation", rotation, 0);
    for (int c = 0; c < 5; c++) begin
      check("spawn_pend_cleared", req_valid, 0);
      tick();
    end

    // Randomized traffic; the per-cycle compare checks everything.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) btn_rot = ~btn_rot;
      if ($urandom_range(0, 7) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
      grav_tick = ($urandom_range(0, 11) == 0);
      spawn     = ($urandom_range(0, 79) == 0);
      chk_done  = (mode == 0) ? 1'b0 : ($urandom_range(0, 2 * mode) == 0);
      chk_ok    = 1'($urandom_range(0, 1));
      tick();
    end
    btn_rot = 0; btn_left = 0; btn_right = 0; btn_down = 0;
    grav_tick = 0; spawn = 0; chk_done = 0; chk_ok = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
